// File: rtl/stark_instr_extract_pkg.sv
// Shared types and constants for the Stark instruction extractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package Stark_pkg;

    localparam int SLOTS  = 16;
    localparam int SLOT_W = 32;
    localparam int LINE_W = SLOTS * SLOT_W;
    localparam int IDX_W  = $clog2(SLOTS);
    localparam int FB_N   = 4;

    // Slot k of a line occupies bits [32k+31:32k].
    typedef logic [SLOTS-1:0][SLOT_W-1:0] line_t;

    typedef struct packed {
        logic [SLOT_W-1:0] ins;
        logic              is_const;
    } ins_t;

    typedef struct packed {
        logic       v;
        ins_t       ins;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [11:0] imm;
    } micro_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } extract_state_t;

    // Valid uop carrying only the raw instruction word; the decoder fills the rest.
    function automatic micro_op_t mk_uop(input logic [SLOT_W-1:0] word);
        micro_op_t u;
        u         = '0;
        u.v       = 1'b1;
        u.ins.ins = word;
        return u;
    endfunction

    // Bits below the start slot are marked as already consumed.
    function automatic logic [SLOTS-1:0] low_mask(input logic [IDX_W-1:0] idx);
        logic [SLOTS-1:0] m;
        for (int k = 0; k < SLOTS; k++) begin
            m[k] = (IDX_W'(k) < idx);
        end
        return m;
    endfunction

    // Byte offset of a slot from the line base.
    function automatic logic [IDX_W+1:0] slot_off(input logic [IDX_W-1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/stark_instr_extract_if.sv
// Bundle between line buffer / decoder and the extractor.
// Latency: n/a (wires only).
// Backpressure: line_v/line_rdy on the line side, uop.v/uop_rdy on the decoder side.
interface stark_instr_extract_if #(
    parameter int PCW = 32
);
    import Stark_pkg::*;

    logic                       flush;
    logic                       line_v;
    logic                       line_rdy;
    logic [LINE_W-1:0]          line_i;
    logic [PCW-1:0]             line_pc;
    logic [IDX_W-1:0]           start_slot;
    micro_op_t                  uop;
    logic [PCW-1:0]             uop_pc;
    logic                       uop_rdy;
    logic [LINE_W-1:0]          cline_o;
    logic [FB_N-1:0]            mark_nops;
    logic [FB_N-1:0][IDX_W-1:0] consts_pos;

    modport slave (
        input  flush, line_v, line_i, line_pc, start_slot, uop_rdy, mark_nops, consts_pos,
        output line_rdy, uop, uop_pc, cline_o
    );

    modport master (
        output flush, line_v, line_i, line_pc, start_slot, uop_rdy, mark_nops, consts_pos,
        input  line_rdy, uop, uop_pc, cline_o
    );

endinterface

// File: rtl/stark_instr_extract_slot_ffs.sv
// Finds the lowest clear mask bit strictly above a base index.
// Latency: combinational.
// Backpressure: none.
module stark_slot_ffs
    import Stark_pkg::*;
(
    input  logic [SLOTS-1:0] mask,
    input  logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (IDX_W'(k) > base && !mask[k]) begin
                idx   = IDX_W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stark_instr_extract.sv
// Splits a cache line into per-slot uops, skipping slots the decoder flags as constants.
// Latency: first uop one cycle after line accept, then one uop per cycle; one bubble between lines.
// Backpressure: uop/uop_pc held while uop_rdy is low; line_rdy low for the whole line.
module stark_instr_extract
    import Stark_pkg::*;
#(
    parameter int PCW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stark_instr_extract_if.slave  bus
);

    extract_state_t   state;
    extract_state_t   state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [SLOTS-1:0] skip;
    line_t            line_q;
    logic [PCW-1:0]   base_pc;
    micro_op_t        uop_q;
    logic [PCW-1:0]   uop_pc_q;

    line_t            line_in;
    logic             accept;
    logic             hs;
    logic [SLOTS-1:0] fb_mask;
    logic [SLOTS-1:0] skip_upd;
    logic [IDX_W-1:0] nxt_ptr;
    logic             nxt_found;

    assign line_in      = bus.line_i;
    assign bus.line_rdy = (state == IDLE) && rst_n;
    assign accept       = bus.line_v && bus.line_rdy && !bus.flush;
    assign hs           = uop_q.v && bus.uop_rdy && !bus.flush;

    assign bus.uop      = uop_q;
    assign bus.uop_pc   = uop_pc_q;
    assign bus.cline_o  = line_q;

    // Decoder constant-slot feedback; positions at or behind ptr are already consumed.
    always_comb begin
        fb_mask = '0;
        for (int i = 0; i < FB_N; i++) begin
            if (bus.mark_nops[i] && bus.consts_pos[i] > ptr) begin
                fb_mask[bus.consts_pos[i]] = 1'b1;
            end
        end
        skip_upd      = skip | fb_mask;
        skip_upd[ptr] = 1'b1;
    end

    stark_slot_ffs u_ffs (
        .mask  (skip_upd),
        .base  (ptr),
        .idx   (nxt_ptr),
        .found (nxt_found)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush wins, otherwise leave RUN after the last live slot handshakes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (hs && !nxt_found) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line capture, slot pointer advance and registered uop outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            skip     <= '0;
            line_q   <= '0;
            base_pc  <= '0;
            uop_q    <= '0;
            uop_pc_q <= '0;
        end else if (bus.flush) begin
            skip  <= '0;
            uop_q <= '0;
        end else if (accept) begin
            line_q   <= line_in;
            base_pc  <= bus.line_pc;
            ptr      <= bus.start_slot;
            skip     <= low_mask(bus.start_slot);
            uop_q    <= mk_uop(line_in[bus.start_slot]);
            uop_pc_q <= bus.line_pc + PCW'(slot_off(bus.start_slot));
        end else if (hs) begin
            if (nxt_found) begin
                skip     <= skip_upd;
                ptr      <= nxt_ptr;
                uop_q    <= mk_uop(line_q[nxt_ptr]);
                uop_pc_q <= base_pc + PCW'(slot_off(nxt_ptr));
            end else begin
                skip  <= '0;
                uop_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stark_instr_extract.sv
// Directed bench with a scoreboard queue for the Stark instruction extractor.
// Latency: n/a.
// Backpressure: drives uop_rdy stalls and flush/reset mid-line.
module tb_stark_instr_extract;
    import Stark_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stark_instr_extract_if #(.PCW(32)) ifc ();

    stark_instr_extract #(.PCW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Decoder feedback model: either a fixed response at one PC or a direct override.
    logic             fb_en = 1'b0;
    logic [31:0]      fb_pc = '0;
    logic [3:0]       fb_mn = '0;
    logic [3:0][3:0]  fb_cp = '0;
    logic             ov_en = 1'b0;
    logic [3:0]       ov_mn = '0;
    logic [3:0][3:0]  ov_cp = '0;

    always_comb begin
        ifc.mark_nops  = '0;
        ifc.consts_pos = fb_cp;
        if (ov_en) begin
            ifc.mark_nops  = ov_mn;
            ifc.consts_pos = ov_cp;
        end else if (fb_en && ifc.uop.v && ifc.uop_pc == fb_pc) begin
            ifc.mark_nops = fb_mn;
        end
    end

    function automatic logic [31:0] word(input int id, input int k);
        return {8'(id), 8'(k), ~8'(id), ~8'(k)};
    endfunction

    function automatic logic [511:0] mk_line(input int id);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = word(id, k);
        return l;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard monitor: every accepted uop must match the head of the queue.
    always @(negedge clk) begin
        exp_t      e;
        micro_op_t eu;
        if (rst_n && !ifc.flush && ifc.uop.v && ifc.uop_rdy) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_uop: got pc %h word %h want none", ifc.uop_pc, ifc.uop.ins.ins);
            end else begin
                e         = q.pop_front();
                eu        = '0;
                eu.v      = 1'b1;
                eu.ins.ins = e.w;
                if (ifc.uop !== eu || ifc.uop_pc !== e.pc) begin
                    n_bad++;
                    $display("FAIL uop: got pc %h uop %h want pc %h uop %h", ifc.uop_pc, ifc.uop, e.pc, eu);
                end
            end
        end
    end

    task automatic push_exp(input int id, input logic [31:0] pc, input int st, input logic [15:0] skipm);
        for (int k = st; k < 16; k++) begin
            if (!skipm[k]) q.push_back('{pc + 32'(4 * k), word(id, k)});
        end
    endtask

    task automatic send_line(input int id, input logic [31:0] pc, input logic [3:0] st);
        int t = 0;
        while (!ifc.line_rdy && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!ifc.line_rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL line_rdy_timeout: got 0 want 1");
        end
        ifc.line_v     = 1'b1;
        ifc.line_i     = mk_line(id);
        ifc.line_pc    = pc;
        ifc.start_slot = st;
        @(posedge clk); #1;
        ifc.line_v = 1'b0;
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        int t = 0;
        while (!(ifc.uop.v && ifc.uop_pc == pc) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("wait_pc", {32'(ifc.uop.v), ifc.uop_pc}, {32'd1, pc});
    endtask

    task automatic wait_done(input string name, input int want_cyc);
        int c = 0;
        while (q.size() != 0 && c < 200) begin
            @(posedge clk); #1; c++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, q.size());
            q.delete();
        end else begin
            if (want_cyc >= 0) chk({name, "_cycles"}, 64'(c), 64'(want_cyc));
            chk({name, "_idle_rdy"}, {63'd0, ifc.line_rdy}, 64'd1);
            chk({name, "_idle_v"}, {63'd0, ifc.uop.v}, 64'd0);
        end
    endtask

    initial begin
        ifc.flush      = 1'b0;
        ifc.line_v     = 1'b0;
        ifc.line_i     = '0;
        ifc.line_pc    = '0;
        ifc.start_slot = '0;
        ifc.uop_rdy    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", {63'd0, ifc.uop.v}, 64'd0);
        chk("rst_pc", 64'(ifc.uop_pc), 64'd0);
        chk("rst_cline", {63'd0, (ifc.cline_o == '0)}, 64'd1);
        chk("rst_line_rdy", {63'd0, ifc.line_rdy}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_line_rdy", {63'd0, ifc.line_rdy}, 64'd1);

        // 1: full line, one uop per cycle
        push_exp(1, 32'h1000, 0, 16'h0000);
        send_line(1, 32'h1000, 4'd0);
        chk("cline", {63'd0, (ifc.cline_o == mk_line(1))}, 64'd1);
        wait_done("full", 16);

        // 2: start near the end
        push_exp(2, 32'h2000, 14, 16'h0000);
        send_line(2, 32'h2000, 4'd14);
        wait_done("start14", 2);

        // 3a: constants at 4 and 5 reported at slot 3
        fb_en = 1'b1; fb_pc = 32'h300C; fb_mn = 4'b0011;
        fb_cp[0] = 4'd4; fb_cp[1] = 4'd5; fb_cp[2] = 4'd9; fb_cp[3] = 4'd10;
        push_exp(3, 32'h3000, 0, 16'h0030);
        send_line(3, 32'h3000, 4'd0);
        wait_done("fb_skip", 14);

        // 3b: feedback at or behind ptr is ignored
        fb_pc = 32'h340C; fb_mn = 4'b0011;
        fb_cp[0] = 4'd2; fb_cp[1] = 4'd3;
        push_exp(9, 32'h3400, 0, 16'h0000);
        send_line(9, 32'h3400, 4'd0);
        wait_done("fb_behind", 16);
        fb_en = 1'b0;

        // 4: stall on slot 7 with changing feedback
        push_exp(4, 32'h4000, 0, 16'h1000);
        send_line(4, 32'h4000, 4'd0);
        wait_pc(32'h401C);
        ifc.uop_rdy = 1'b0;
        ov_en = 1'b1; ov_mn = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 4; i++) ov_cp[i] = 4'(8 + ((c + i) % 8));
            @(posedge clk); #1;
            chk("stall_pc", 64'(ifc.uop_pc), 64'h401C);
            chk("stall_word", 64'(ifc.uop.ins.ins), 64'(word(4, 7)));
        end
        ov_mn = 4'b0001;
        ov_cp[0] = 4'd12; ov_cp[1] = 4'd13; ov_cp[2] = 4'd14; ov_cp[3] = 4'd15;
        ifc.uop_rdy = 1'b1;
        @(posedge clk); #1;
        ov_en = 1'b0;
        wait_done("stall", -1);

        // 5: flush at slot 9 while a line is offered
        push_exp(5, 32'h5000, 0, 16'hFE00);
        send_line(5, 32'h5000, 4'd0);
        wait_pc(32'h5024);
        ifc.flush      = 1'b1;
        ifc.uop_rdy    = 1'b0;
        ifc.line_v     = 1'b1;
        ifc.line_i     = mk_line(6);
        ifc.line_pc    = 32'h6000;
        ifc.start_slot = 4'd3;
        @(posedge clk); #1;
        ifc.flush   = 1'b0;
        ifc.line_v  = 1'b0;
        ifc.uop_rdy = 1'b1;
        chk("flush_v", {63'd0, ifc.uop.v}, 64'd0);
        chk("flush_drain", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
        chk("flush_no_accept", {63'd0, ifc.uop.v}, 64'd0);
        push_exp(6, 32'h6000, 3, 16'h0000);
        send_line(6, 32'h6000, 4'd3);
        wait_done("post_flush", 13);

        // 6: reset at slot 5
        push_exp(7, 32'h7000, 2, 16'hFFE0);
        send_line(7, 32'h7000, 4'd2);
        wait_pc(32'h7014);
        rst_n       = 1'b0;
        ifc.uop_rdy = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_v", {63'd0, ifc.uop.v}, 64'd0);
        chk("mid_rst_pc", 64'(ifc.uop_pc), 64'd0);
        chk("mid_rst_cline", {63'd0, (ifc.cline_o == '0)}, 64'd1);
        chk("mid_rst_line_rdy", {63'd0, ifc.line_rdy}, 64'd0);
        chk("mid_rst_drain", 64'(q.size()), 64'd0);
        rst_n       = 1'b1;
        ifc.uop_rdy = 1'b1;
        #1;
        chk("mid_rel_line_rdy", {63'd0, ifc.line_rdy}, 64'd1);
        push_exp(8, 32'h8000, 5, 16'h0000);
        send_line(8, 32'h8000, 4'd5);
        wait_done("post_rst", 11);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
